cr_bmu_dbus_resp: RTL and testbench
===================================

// Module: cr_bmu_dbus_resp
// PURPOSE
// - BMU-side responder to the LSU data-bus request interface.
// - Accepts LSU requests, drives the AHB-Lite data-bus master and returns grant, completion, read data and access error to the LSU.
// - Sits between cr_lsu_ctrl and the system AHB-Lite data port.
// - Supports one address phase overlapping one data phase, for LSU fast-retire back-to-back traffic.
// PARAMETERS
// - REGION_BASE  32'h0000_0000  base of the legal data region (used only with CR_BMU_DBUS_REGION_CHK_EN)
// - REGION_MASK  32'hE000_0000  address bits compared against REGION_BASE
// PORTS
// - forever_cpuclk           in   1   single clock, rising edge
// - cpurst_b                 in   1   asynchronous, active-low reset
// - lsu_bmu_req              in   1   request; held by the LSU until granted
// - lsu_bmu_addr             in   32  request address
// - lsu_bmu_write            in   1   1 = store, 0 = load
// - lsu_bmu_size             in   2   0 = byte, 1 = half, 2 = word
// - lsu_bmu_prot             in   4   HPROT value
// - lsu_bmu_wdata            in   32  store data, valid with req
// - lsu_bmu_addr_check_fail  in   1   LSU-detected illegal access
// - bmu_lsu_grnt             out  1   request accepted this cycle
// - bmu_lsu_trans_cmplt      out  1   data phase of oldest access finished
// - bmu_lsu_data_vld         out  1   load data valid on bmu_lsu_rdata
// - bmu_lsu_rdata            out  32  load data
// - bmu_lsu_acc_err          out  1   access error, coincident with trans_cmplt
// - htrans                   out  2   AHB transfer type (IDLE / NONSEQ only)
// - haddr                    out  32  AHB address
// - hwrite                   out  1   AHB direction
// - hsize                    out  3   AHB size, {1'b0, lsu_bmu_size}
// - hprot                    out  4   AHB protection
// - hwdata                   out  32  AHB write data
// - hready                   in   1   AHB transfer done / ready
// - hresp                    in   1   AHB error response
// - hrdata                   in   32  AHB read data
// BEHAVIOUR
// Slots
// - Two register slots:
//   - A (address phase): a_vld, addr, write, size, prot, wdata, fail.
//   - D (data phase): d_vld, write, wdata, fail.
// Grant
// - bmu_lsu_grnt = lsu_bmu_req & (!a_vld | a_adv) & !err1.
// - a_adv = a_vld & (!d_vld | d_done).
// - Grant is combinational; the request is captured into A at the next clock edge.
// - Address phase starts one cycle after grant. No grant while a is held and cannot advance.
// AHB outputs
// - htrans = NONSEQ when a_vld & !a_fail, else IDLE.
// - haddr/hwrite/hsize/hprot come only from A and are stable while hready = 0.
// - hwdata comes from D.
// A -> D transfer
// - Occurs when a_vld, hready = 1 and D is empty or completing.
// - A failed slot moves to D without any bus transfer.
// Data phase completion (d_done)
// - Bus access: d_vld & hready.
// - Failed slot: d_vld & d_fail; completes in its single D cycle and ignores hready.
// Responses (same cycle as d_done)
// - bmu_lsu_trans_cmplt = 1.
// - bmu_lsu_acc_err = hresp | d_fail.
// - bmu_lsu_data_vld = !d_write & !acc_err.
// - bmu_lsu_rdata = hrdata when data_vld, else 0.
// Error response
// - err1 = d_vld & !d_fail & hresp & !hready.
// - During err1, A is cancelled: a_vld is cleared at the edge, so htrans = IDLE in the second error cycle.
// - The cancelled access gets no trans_cmplt; the LSU invalidates it on acc_err.
// Ordering
// - Responses are strictly in grant order.
// - At most 2 accesses are outstanding.
// Boundaries
// - Grant in the same cycle as d_done and a_adv is legal and gives full throughput: 1 access per cycle at hready = 1.
// - hready = 0 holds both slots unchanged.
// Reset
// - All slots are invalid.
// - Outputs: grnt, trans_cmplt, data_vld, acc_err = 0; rdata = 0; htrans = IDLE; haddr, hwdata = 0; hsize, hprot, hwrite = 0.
// - Reset mid-transfer drops all outstanding accesses with no response.
// CONFIGURATION
// - CR_BMU_DBUS_REGION_CHK_EN defined:
//   - The fail bit is set when lsu_bmu_addr_check_fail | ((lsu_bmu_addr & REGION_MASK) != REGION_BASE).
// - Macro not defined:
//   - The fail bit is lsu_bmu_addr_check_fail only; REGION_* are unused.
// TESTING
// - Single load at 0x100, hready = 1:
//   - Grant in C0, NONSEQ in C1.
//   - C2: trans_cmplt = 1, data_vld = 1, rdata = hrdata = 0xA5A5_5A5A.
// - Store at 0x200 then load at 0x204, req held continuously:
//   - Grants in C0 and C1; haddr 0x200 in C1 and 0x204 in C2.
//   - hwdata = store data in C2; two trans_cmplt pulses in C2 and C3.
// - Load with 3 hready = 0 wait states in the data phase, second request pending:
//   - haddr, htrans and hsize stay stable; no grant while A is blocked.
//   - trans_cmplt is asserted only on the hready = 1 cycle.
// - Store gets ERROR (hresp = 1 and hready = 0, then hresp = 1 and hready = 1) with a load in A:
//   - htrans = IDLE in the 2nd error cycle.
//   - acc_err = 1 and trans_cmplt = 1 once; no response for the cancelled load.
// - Request with addr_check_fail = 1:
//   - Granted, htrans stays IDLE.
//   - Two cycles later: trans_cmplt = 1, acc_err = 1, data_vld = 0.
// - Region check and reset:
//   - With the macro defined, a load at 0xE000_0000 gets acc_err and no bus transfer.
//   - cpurst_b low mid data phase gives all outputs at reset values.

Source files
------------

// File: rtl/cr_bmu_dbus_resp.sv
// cr_bmu_dbus_resp: LSU data-bus responder driving an AHB-Lite master with one
// address phase (slot A) overlapping one data phase (slot D).
// Optional feature: define CR_BMU_DBUS_REGION_CHK_EN to also fail accesses whose
// address falls outside REGION_BASE/REGION_MASK.
module cr_bmu_dbus_resp #(
  parameter logic [31:0] REGION_BASE = 32'h0000_0000,
  parameter logic [31:0] REGION_MASK = 32'hE000_0000
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        lsu_bmu_req,
  input  logic [31:0] lsu_bmu_addr,
  input  logic        lsu_bmu_write,
  input  logic [1:0]  lsu_bmu_size,
  input  logic [3:0]  lsu_bmu_prot,
  input  logic [31:0] lsu_bmu_wdata,
  input  logic        lsu_bmu_addr_check_fail,
  output logic        bmu_lsu_grnt,
  output logic        bmu_lsu_trans_cmplt,
  output logic        bmu_lsu_data_vld,
  output logic [31:0] bmu_lsu_rdata,
  output logic        bmu_lsu_acc_err,
  output logic [1:0]  htrans,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata
);
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  logic        a_vld, a_write, a_fail;
  logic [31:0] a_addr, a_wdata;
  logic [1:0]  a_size;
  logic [3:0]  a_prot;
  logic        d_vld, d_write, d_fail;
  logic [31:0] d_wdata;
  logic        req_fail, d_done, a_adv, err1, acc_err, data_vld;
`ifdef CR_BMU_DBUS_REGION_CHK_EN
  assign req_fail = lsu_bmu_addr_check_fail | ((lsu_bmu_addr & REGION_MASK) != REGION_BASE);
`else
  logic unused_region;
  assign unused_region = ^(REGION_BASE & REGION_MASK);
  assign req_fail = lsu_bmu_addr_check_fail;
`endif
  // A failed slot finishes in one D cycle with no bus involvement, so hready is ignored for it
  assign d_done = d_vld & (d_fail | hready);
  // First cycle of a two-cycle AHB ERROR response on a real bus access
  assign err1 = d_vld & ~d_fail & hresp & ~hready;
  // A bus address phase completes only with hready; a failed slot never reaches the bus
  assign a_adv = a_vld & (~d_vld | d_done) & (a_fail | hready);
  assign bmu_lsu_grnt = cpurst_b & lsu_bmu_req & (~a_vld | a_adv) & ~err1;
  assign acc_err = d_done & (hresp | d_fail);
  assign data_vld = d_done & ~d_write & ~acc_err;
  assign bmu_lsu_trans_cmplt = d_done;
  assign bmu_lsu_acc_err = acc_err;
  assign bmu_lsu_data_vld = data_vld;
  assign bmu_lsu_rdata = data_vld ? hrdata : 32'h0;
  assign htrans = (a_vld & ~a_fail) ? NONSEQ : IDLE;
  assign haddr = a_addr;
  assign hwrite = a_write;
  assign hsize = {1'b0, a_size};
  assign hprot = a_prot;
  assign hwdata = d_wdata;
  // Address slot: cancelled on an error response, loaded on grant, emptied when it advances
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      a_vld   <= 1'b0;
      a_addr  <= 32'h0;
      a_write <= 1'b0;
      a_size  <= 2'b0;
      a_prot  <= 4'h0;
      a_wdata <= 32'h0;
      a_fail  <= 1'b0;
    end else if (err1) begin
      a_vld <= 1'b0;
    end else if (bmu_lsu_grnt) begin
      a_vld   <= 1'b1;
      a_addr  <= lsu_bmu_addr;
      a_write <= lsu_bmu_write;
      a_size  <= lsu_bmu_size;
      a_prot  <= lsu_bmu_prot;
      a_wdata <= lsu_bmu_wdata;
      a_fail  <= req_fail;
    end else if (a_adv) begin
      a_vld <= 1'b0;
    end
  end
  // Data slot: takes over the address slot when it advances, emptied once its data phase ends
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      d_vld   <= 1'b0;
      d_write <= 1'b0;
      d_wdata <= 32'h0;
      d_fail  <= 1'b0;
    end else if (a_adv) begin
      d_vld   <= 1'b1;
      d_write <= a_write;
      d_wdata <= a_wdata;
      d_fail  <= a_fail;
    end else if (d_done) begin
      d_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cr_bmu_dbus_resp.sv
// tb_cr_bmu_dbus_resp: scoreboard bench with a behavioural AHB slave and LSU reference model.
module tb_cr_bmu_dbus_resp;
  logic        forever_cpuclk = 1'b0;
  logic        cpurst_b = 1'b0;
  logic        lsu_bmu_req = 1'b0;
  logic [31:0] lsu_bmu_addr = 32'h0;
  logic        lsu_bmu_write = 1'b0;
  logic [1:0]  lsu_bmu_size = 2'b0;
  logic [3:0]  lsu_bmu_prot = 4'h0;
  logic [31:0] lsu_bmu_wdata = 32'h0;
  logic        lsu_bmu_addr_check_fail = 1'b0;
  logic        bmu_lsu_grnt, bmu_lsu_trans_cmplt, bmu_lsu_data_vld, bmu_lsu_acc_err;
  logic [31:0] bmu_lsu_rdata;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;
  logic [31:0] hrdata = 32'h0;

  cr_bmu_dbus_resp dut (
    .forever_cpuclk(forever_cpuclk), .cpurst_b(cpurst_b),
    .lsu_bmu_req(lsu_bmu_req), .lsu_bmu_addr(lsu_bmu_addr), .lsu_bmu_write(lsu_bmu_write),
    .lsu_bmu_size(lsu_bmu_size), .lsu_bmu_prot(lsu_bmu_prot), .lsu_bmu_wdata(lsu_bmu_wdata),
    .lsu_bmu_addr_check_fail(lsu_bmu_addr_check_fail),
    .bmu_lsu_grnt(bmu_lsu_grnt), .bmu_lsu_trans_cmplt(bmu_lsu_trans_cmplt),
    .bmu_lsu_data_vld(bmu_lsu_data_vld), .bmu_lsu_rdata(bmu_lsu_rdata),
    .bmu_lsu_acc_err(bmu_lsu_acc_err),
    .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hprot(hprot),
    .hwdata(hwdata), .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [3:0]  pr;
    logic [31:0] wd;
    logic        f;
    int          g;
  } acc_t;

  acc_t        q[$];
  bit          bq[$];
  acc_t        last, e;
  logic [31:0] mem [8];
  logic [31:0] ref_mem [8];
  int          checks = 0, errors = 0, cyc = 0, err_cyc = -1;
  bit          dp = 0, dp_w = 0, dp_err = 0, es = 0;
  logic [31:0] dp_a = 0, dp_wd = 0;
  int          waits = 0, minw = 0, maxw = 0;
  bit          err_en = 0, err_force = 0, fast_chk = 0;
  bit          prev_hold = 0;
  logic [41:0] ap, prev_ap = 0;
  logic        x_err, x_dv, be;
  logic [31:0] x_rd;

  function automatic logic model_fail(input logic [31:0] a, input logic f);
`ifdef CR_BMU_DBUS_REGION_CHK_EN
    return f | ((a & 32'hE000_0000) != 32'h0);
`else
    return f;
`endif
  endfunction

  // AHB slave drive: wait states, two-cycle ERROR, read data from slave memory
  always @(posedge forever_cpuclk) begin
    #1;
    if (!dp) {hready, hresp} = 2'b10;
    else if (waits > 0) {hready, hresp} = 2'b00;
    else if (dp_err && !es) {hready, hresp} = 2'b01;
    else if (dp_err) {hready, hresp} = 2'b11;
    else {hready, hresp} = 2'b10;
    hrdata = (dp && !dp_w && !dp_err && waits == 0) ? mem[dp_a[4:2]] : $urandom;
  end

  // Sampling at the falling edge: slave bookkeeping, scoreboard checks, grant capture
  always @(negedge forever_cpuclk) begin
    cyc++;
    if (!cpurst_b) begin
      checks++;
      if ({bmu_lsu_grnt, bmu_lsu_trans_cmplt, bmu_lsu_data_vld, bmu_lsu_acc_err, bmu_lsu_rdata,
           htrans, haddr, hwrite, hsize, hprot, hwdata} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: grnt=%b cmplt=%b dv=%b err=%b rdata=%h htrans=%b haddr=%h hwrite=%b hsize=%h hprot=%h hwdata=%h, required all 0",
                 bmu_lsu_grnt, bmu_lsu_trans_cmplt, bmu_lsu_data_vld, bmu_lsu_acc_err, bmu_lsu_rdata,
                 htrans, haddr, hwrite, hsize, hprot, hwdata);
      end
      q.delete();
      bq.delete();
      dp = 0;
      es = 0;
      prev_hold = 0;
    end else begin
      ap = {htrans, haddr, hwrite, hsize, hprot};
      if (prev_hold) begin
        checks++;
        if (ap !== prev_ap) begin
          errors++;
          $display("FAIL wait_stable: addr phase %h, required %h", ap, prev_ap);
        end
      end
      if (htrans == 2'b10 && !hready) begin
        checks++;
        if (bmu_lsu_grnt !== 1'b0) begin
          errors++;
          $display("FAIL no_grant_blocked: grnt=%b, required 0", bmu_lsu_grnt);
        end
      end
      if (fast_chk && lsu_bmu_req) begin
        checks++;
        if (bmu_lsu_grnt !== 1'b1) begin
          errors++;
          $display("FAIL full_throughput: grnt=%b at cycle %0d, required 1", bmu_lsu_grnt, cyc);
        end
      end
      if (dp && !hready) begin
        if (waits > 0) waits--;
        else if (hresp) begin
          es = 1;
          err_cyc = cyc;
        end
      end
      if (dp && hready && dp_w) begin
        checks++;
        if (hwdata !== dp_wd) begin
          errors++;
          $display("FAIL hwdata: got %h, required %h", hwdata, dp_wd);
        end
        if (!dp_err) mem[dp_a[4:2]] = hwdata;
      end
      checks++;
      if (bmu_lsu_trans_cmplt) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmplt: cmplt=1 at cycle %0d, required no response", cyc);
        end else begin
          e = q.pop_front();
          be = 1'b0;
          if (!e.f && bq.size() > 0) be = bq.pop_front();
          x_err = e.f | be;
          x_dv = !e.w && !x_err;
          x_rd = x_dv ? ref_mem[e.a[4:2]] : 32'h0;
          if ({bmu_lsu_acc_err, bmu_lsu_data_vld, bmu_lsu_rdata} !== {x_err, x_dv, x_rd}) begin
            errors++;
            $display("FAIL response addr=%h w=%b: err=%b dv=%b rdata=%h, required err=%b dv=%b rdata=%h",
                     e.a, e.w, bmu_lsu_acc_err, bmu_lsu_data_vld, bmu_lsu_rdata, x_err, x_dv, x_rd);
          end
          if (e.w && !x_err) ref_mem[e.a[4:2]] = e.wd;
          if (!e.f && be && q.size() > 0 && q[0].g < err_cyc) void'(q.pop_front());
        end
      end else if (bmu_lsu_data_vld || bmu_lsu_acc_err) begin
        errors++;
        $display("FAIL idle_response: dv=%b err=%b without cmplt, required 0", bmu_lsu_data_vld, bmu_lsu_acc_err);
      end
      if (hready) begin
        if (htrans == 2'b10) begin
          checks++;
          if ({haddr, hwrite, hsize, hprot, 1'b0} !== {last.a, last.w, 1'b0, last.sz, last.pr, last.f}) begin
            errors++;
            $display("FAIL addr_phase: haddr=%h hwrite=%b hsize=%h hprot=%h, required %h %b %h %h (fail=%b)",
                     haddr, hwrite, hsize, hprot, last.a, last.w, {1'b0, last.sz}, last.pr, last.f);
          end
          dp = 1;
          dp_a = haddr;
          dp_w = hwrite;
          dp_wd = last.wd;
          waits = $urandom_range(maxw, minw);
          dp_err = err_force || (err_en && $urandom_range(0, 5) == 0);
          es = 0;
          bq.push_back(dp_err);
        end else dp = 0;
      end
      if (bmu_lsu_grnt) begin
        last.w = lsu_bmu_write;
        last.a = lsu_bmu_addr;
        last.sz = lsu_bmu_size;
        last.pr = lsu_bmu_prot;
        last.wd = lsu_bmu_wdata;
        last.f = model_fail(lsu_bmu_addr, lsu_bmu_addr_check_fail);
        last.g = cyc;
        q.push_back(last);
      end
      prev_hold = htrans == 2'b10 && !hready && !hresp;
      prev_ap = ap;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge forever_cpuclk);
      #1;
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] sz,
                       input logic [3:0] pr, input logic [31:0] wd, input logic f);
    int n = 0;
    lsu_bmu_req = 1'b1;
    lsu_bmu_write = w;
    lsu_bmu_addr = a;
    lsu_bmu_size = sz;
    lsu_bmu_prot = pr;
    lsu_bmu_wdata = wd;
    lsu_bmu_addr_check_fail = f;
    do begin
      @(negedge forever_cpuclk);
      n++;
    end while (!bmu_lsu_grnt && n < 60);
    if (!bmu_lsu_grnt) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: no grant after %0d cycles for addr %h, required grant", n, a);
    end
    @(posedge forever_cpuclk);
    #1;
    lsu_bmu_req = 1'b0;
    lsu_bmu_addr_check_fail = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] base;
    base = ($urandom_range(0, 7) == 0) ? 32'hE000_0100 : 32'h0000_0100;
    return base + 32'($urandom_range(0, 7) * 4);
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'hA5A5_5A5A;
    ref_mem[0] = 32'hA5A5_5A5A;
    repeat (3) @(negedge forever_cpuclk);
    @(posedge forever_cpuclk);
    #3 cpurst_b = 1'b1;
    idle(2);
    issue(1'b0, 32'h100, 2'd2, 4'h3, 32'h0, 1'b0);
    idle(3);
    issue(1'b1, 32'h200, 2'd2, 4'h1, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 32'h204, 2'd1, 4'h1, 32'h0, 1'b0);
    idle(3);
    minw = 3;
    maxw = 3;
    issue(1'b0, 32'h108, 2'd2, 4'h2, 32'h0, 1'b0);
    issue(1'b0, 32'h10C, 2'd0, 4'h2, 32'h0, 1'b0);
    idle(8);
    minw = 0;
    maxw = 0;
    err_force = 1;
    issue(1'b1, 32'h110, 2'd2, 4'h1, 32'h1234_5678, 1'b0);
    issue(1'b0, 32'h114, 2'd2, 4'h1, 32'h0, 1'b0);
    err_force = 0;
    idle(4);
    issue(1'b0, 32'h118, 2'd2, 4'h1, 32'h0, 1'b1);
    idle(3);
    issue(1'b0, 32'hE000_0000, 2'd2, 4'h1, 32'h0, 1'b0);
    idle(5);
    fast_chk = 1;
    for (int i = 0; i < 10; i++)
      issue(1'($urandom_range(0, 1)), 32'h100 + 32'(i % 8) * 4, 2'd2, 4'h3, $urandom, 1'b0);
    fast_chk = 0;
    idle(4);
    maxw = 2;
    err_en = 1;
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), rnd_addr(), 2'($urandom_range(0, 2)), 4'($urandom),
            $urandom, $urandom_range(0, 9) == 0);
      idle($urandom_range(0, 2));
    end
    err_en = 0;
    idle(10);
    minw = 3;
    maxw = 3;
    issue(1'b0, 32'h104, 2'd2, 4'h3, 32'h0, 1'b0);
    @(posedge forever_cpuclk);
    #3;
    cpurst_b = 1'b0;
    lsu_bmu_req = 1'b1;
    repeat (2) @(negedge forever_cpuclk);
    @(posedge forever_cpuclk);
    #1 lsu_bmu_req = 1'b0;
    #2 cpurst_b = 1'b1;
    minw = 0;
    maxw = 0;
    idle(2);
    issue(1'b0, 32'h100, 2'd2, 4'h3, 32'h0, 1'b0);
    idle(10);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d accesses without response, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
